// File: rtl/burst_accumulator_18_pkg.sv
// Shared widths and state encoding for the 18-bit burst accumulator.
package burst_accumulator_18_pkg;

    localparam int DATA_W     = 18;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/burst_accumulator_18_carry_chain_add18.sv
// 18-bit ripple-carry adder built from full_adder cells, carry-in tied low.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module carry_chain_add18
    import burst_accumulator_18_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);
    logic [DATA_W:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .s    (sum[i]),
            .cout (carry_s[i+1])
        );
    end

    assign cout = carry_s[DATA_W];
endmodule

// File: rtl/burst_accumulator_18.sv
// Accumulates a burst of 18-bit operands and presents sum, sticky carry and
// saturating count on a valid/ready result port.
module burst_accumulator_18
    import burst_accumulator_18_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    output logic [CNT_W-1:0]  out_count
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_sum_q, out_sum_d;
    logic                out_carry_q, out_carry_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;

    logic [DATA_W-1:0]   add_sum_s;
    logic                add_cout_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic                accept_s;
    logic                out_hs_s;

    carry_chain_add18 u_add (
        .a    (acc_q),
        .b    (in_data),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    assign accept_s  = in_valid & in_ready_q;
    assign out_hs_s  = out_valid_q & out_ready;
    assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                                : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, accumulator and result-register logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_count_d = out_count_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    acc_d    = add_sum_s;
                    sticky_d = sticky_q | add_cout_s;
                    cnt_d    = cnt_inc_s;
                    if (in_last) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_sum_d   = add_sum_s;
                        out_carry_d = sticky_q | add_cout_s;
                        out_count_d = cnt_inc_s;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                if (out_hs_s) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    acc_d       = {DATA_W{1'b0}};
                    sticky_d    = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                acc_d       = {DATA_W{1'b0}};
                sticky_d    = 1'b0;
                cnt_d       = {CNT_W{1'b0}};
            end
        endcase

        // in_ready is registered, so the DONE->IDLE handshake costs one bubble.
        in_ready_d = (state_d != DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= {DATA_W{1'b0}};
            sticky_q    <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= {DATA_W{1'b0}};
            out_carry_q <= 1'b0;
            out_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_burst_accumulator_18.sv
// Directed and randomized bursts checked against an arithmetic burst model.
module tb_burst_accumulator_18;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_sum;
    logic        out_carry;
    logic [7:0]  out_count;

    int vectors     = 0;
    int miscompares = 0;
    bit gaps        = 1'b0;

    logic [17:0] bdata[$];

    burst_accumulator_18 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat and return at posedge+1 of the edge that took it.
    task automatic send_beat(input logic [17:0] d, input logic l);
        int  guard;
        bit  took;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        guard    = 0;
        took     = 1'b0;
        while (!took && guard < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!took) begin
            vectors++;
            miscompares++;
            $error("FAIL accept_timeout observed=%0d expected=%0d", 0, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 18'h0;
    endtask

    // Send bdata as one burst, check the result, hold it `hold` cycles, then drain.
    task automatic do_burst(input int hold);
        longint      total;
        int          n;
        logic [17:0] e_sum;
        logic        e_carry;
        logic [7:0]  e_cnt;
        n     = bdata.size();
        total = 0;
        foreach (bdata[i]) total += longint'(bdata[i]);
        e_sum   = 18'(total % 262144);
        e_carry = (total >= 262144);
        e_cnt   = (n > 255) ? 8'd255 : 8'(n);
        out_ready = (hold == 0);
        foreach (bdata[i]) send_beat(bdata[i], (i == n - 1));
        chk("out_valid_lat1", out_valid, 1);
        chk("in_ready_done", in_ready, 0);
        chk("out_sum", out_sum, e_sum);
        chk("out_carry", out_carry, e_carry);
        chk("out_count", out_count, e_cnt);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = 18'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, e_sum);
            chk("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("sum_kept", out_sum, e_sum);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 18'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", out_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", in_ready, 1);

        // 1: simple burst
        bdata = '{18'h00001, 18'h00002, 18'h00003};
        do_burst(0);
        // 2: wrap sets sticky carry, next burst clears it
        bdata = '{18'h3FFFF, 18'h00002};
        do_burst(0);
        bdata = '{18'h00004};
        do_burst(0);
        chk("sticky_cleared", out_carry, 0);
        // 3: backpressure holds result
        bdata = '{18'h10000, 18'h00100};
        do_burst(5);
        // 4: single beat after backpressure starts from zero
        bdata = '{18'h2AAAA};
        do_burst(0);

        // 5: async reset mid-burst
        send_beat(18'h00005, 1'b0);
        send_beat(18'h00005, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sum", out_sum, 0);
        chk("arst_carry", out_carry, 0);
        chk("arst_count", out_count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_arst", in_ready, 1);
        bdata = '{18'h00005, 18'h00005};
        do_burst(0);

        // 6: counter saturation
        bdata = {};
        for (int i = 0; i < 300; i++) bdata.push_back(18'h00001);
        do_burst(0);

        // Randomized bursts with gaps, large operands and backpressure.
        gaps = 1'b1;
        for (int b = 0; b < 25; b++) begin
            bdata = {};
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
                if ($urandom_range(0, 3) == 0)
                    bdata.push_back(18'($urandom_range(262000, 262143)));
                else
                    bdata.push_back(18'($urandom_range(0, 262143)));
            end
            do_burst(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
